// File: rtl/mc_cpu_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states, ALU codes,
// opcode/funct values, datapath select encodings and decoded instruction classes.
package mc_cpu_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd5
  } state_t;

  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;

  typedef enum logic [1:0] {SRCA_PC, SRCA_RS, SRCA_SA, SRCA_IMM}    srca_t;
  typedef enum logic [1:0] {SRCB_RT, SRCB_FOUR, SRCB_IMM, SRCB_BR}  srcb_t;
  typedef enum logic [1:0] {PC_ALU, PC_ALUOUT, PC_RS, PC_JUMP}      pcsrc_t;

  typedef enum logic [3:0] {
    CLS_ILLEGAL,
    CLS_RALU,
    CLS_SHIFT,
    CLS_IALU,
    CLS_LUI,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_BNE,
    CLS_J,
    CLS_JAL,
    CLS_JR
  } iclass_t;

endpackage

// File: rtl/mc_control_unit_if.sv
// Control bus between the multi-cycle control unit (master) and the datapath (slave).
interface mc_control_unit_if;
  logic [5:0] op;
  logic [5:0] func;
  logic       z;
  logic       mem_ready;
  logic [3:0] aluc;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsource;
  logic       wpc;
  logic       iord;
  logic       wir;
  logic       wmem;
  logic       wreg;
  logic       regrt;
  logic       m2reg;
  logic       sext;
  logic       jal;
  logic [2:0] state;
  logic       illegal;

  modport master (
    input  op, func, z, mem_ready,
    output aluc, alusrca, alusrcb, pcsource, wpc, iord, wir, wmem, wreg,
           regrt, m2reg, sext, jal, state, illegal
  );

  modport slave (
    output op, func, z, mem_ready,
    input  aluc, alusrca, alusrcb, pcsource, wpc, iord, wir, wmem, wreg,
           regrt, m2reg, sext, jal, state, illegal
  );
endinterface

// File: rtl/mc_control_unit_alu_dec.sv
// Combinational instruction decoder: op/func to ALU code, execute-stage operand
// selects, immediate extension, destination select and instruction class.
module mc_alu_dec
  import mc_cpu_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_func,
  output logic [3:0] o_aluc,
  output srca_t      o_alusrca,
  output srcb_t      o_alusrcb,
  output logic       o_sext,
  output logic       o_regrt,
  output iclass_t    o_iclass
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    o_aluc    = ALUC_ADD;
    o_alusrca = SRCA_RS;
    o_alusrcb = SRCB_RT;
    o_sext    = 1'b0;
    o_regrt   = 1'b0;
    o_iclass  = CLS_ILLEGAL;

    case (i_op)
      OP_RTYPE: begin
        case (i_func)
          FN_ADD: o_iclass = CLS_RALU;
          FN_SUB: begin o_iclass = CLS_RALU; o_aluc = ALUC_SUB; end
          FN_AND: begin o_iclass = CLS_RALU; o_aluc = ALUC_AND; end
          FN_OR:  begin o_iclass = CLS_RALU; o_aluc = ALUC_OR;  end
          FN_XOR: begin o_iclass = CLS_RALU; o_aluc = ALUC_XOR; end
          FN_SLL: begin o_iclass = CLS_SHIFT; o_aluc = ALUC_SLL; o_alusrca = SRCA_SA; end
          FN_SRL: begin o_iclass = CLS_SHIFT; o_aluc = ALUC_SRL; o_alusrca = SRCA_SA; end
          FN_SRA: begin o_iclass = CLS_SHIFT; o_aluc = ALUC_SRA; o_alusrca = SRCA_SA; end
          FN_JR:  o_iclass = CLS_JR;
          default: ;
        endcase
      end
      OP_ADDI: begin
        o_iclass = CLS_IALU; o_alusrcb = SRCB_IMM; o_sext = 1'b1; o_regrt = 1'b1;
      end
      OP_ANDI: begin
        o_iclass = CLS_IALU; o_aluc = ALUC_AND; o_alusrcb = SRCB_IMM; o_regrt = 1'b1;
      end
      OP_ORI: begin
        o_iclass = CLS_IALU; o_aluc = ALUC_OR; o_alusrcb = SRCB_IMM; o_regrt = 1'b1;
      end
      OP_XORI: begin
        o_iclass = CLS_IALU; o_aluc = ALUC_XOR; o_alusrcb = SRCB_IMM; o_regrt = 1'b1;
      end
      // lui routes the zero-extended immediate to A; the ALU shifts it left by 16.
      OP_LUI: begin
        o_iclass = CLS_LUI; o_aluc = ALUC_LUI; o_alusrca = SRCA_IMM;
        o_alusrcb = SRCB_IMM; o_regrt = 1'b1;
      end
      OP_LW: begin
        o_iclass = CLS_LW; o_alusrcb = SRCB_IMM; o_sext = 1'b1; o_regrt = 1'b1;
      end
      OP_SW: begin
        o_iclass = CLS_SW; o_alusrcb = SRCB_IMM; o_sext = 1'b1; o_regrt = 1'b1;
      end
      OP_BEQ: begin
        o_iclass = CLS_BEQ; o_aluc = ALUC_SUB; o_sext = 1'b1; o_regrt = 1'b1;
      end
      OP_BNE: begin
        o_iclass = CLS_BNE; o_aluc = ALUC_SUB; o_sext = 1'b1; o_regrt = 1'b1;
      end
      OP_J:   o_iclass = CLS_J;
      OP_JAL: o_iclass = CLS_JAL;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control FSM (IF/ID/EXE/MEM/WB). Define MC_ILLEGAL_TRAP_EN to
// trap undefined opcodes in a sticky TRAP state; otherwise they retire as NOPs.
module mc_control_unit
  import mc_cpu_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  mc_control_unit_if.master   bus
);

  state_t  r_state;
  iclass_t w_iclass;
  logic [3:0] w_dec_aluc;
  srca_t   w_dec_alusrca;
  srcb_t   w_dec_alusrcb;
  logic    w_dec_sext;
  logic    w_dec_regrt;

  logic [3:0] w_aluc;
  srca_t   w_alusrca;
  srcb_t   w_alusrcb;
  pcsrc_t  w_pcsource;
  logic    w_wpc, w_iord, w_wir, w_wmem, w_wreg, w_regrt, w_m2reg, w_sext, w_jal;

  mc_alu_dec u_dec (
    .i_op      (bus.op),
    .i_func    (bus.func),
    .o_aluc    (w_dec_aluc),
    .o_alusrca (w_dec_alusrca),
    .o_alusrcb (w_dec_alusrcb),
    .o_sext    (w_dec_sext),
    .o_regrt   (w_dec_regrt),
    .o_iclass  (w_iclass)
  );

`ifdef MC_ILLEGAL_TRAP_EN
  logic r_illegal;
`endif

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (reset) begin
      r_state <= S_IF;
`ifdef MC_ILLEGAL_TRAP_EN
      r_illegal <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IF:  if (bus.mem_ready) r_state <= S_ID;
        S_ID: begin
          case (w_iclass)
            CLS_J, CLS_JAL, CLS_JR: r_state <= S_IF;
            CLS_ILLEGAL: begin
`ifdef MC_ILLEGAL_TRAP_EN
              r_state   <= S_TRAP;
              r_illegal <= 1'b1;
`else
              r_state <= S_IF;
`endif
            end
            default: r_state <= S_EXE;
          endcase
        end
        S_EXE: begin
          case (w_iclass)
            CLS_BEQ, CLS_BNE: r_state <= S_IF;
            CLS_LW, CLS_SW:   r_state <= S_MEM;
            default:          r_state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (bus.mem_ready) r_state <= (w_iclass == CLS_LW) ? S_WB : S_IF;
        end
        S_WB: r_state <= S_IF;
`ifdef MC_ILLEGAL_TRAP_EN
        S_TRAP: r_state <= S_TRAP;
`endif
        default: r_state <= S_IF;
      endcase
    end
  end

  // Outputs follow the registered state but are refined by the live op/func/z/
  // mem_ready inputs so handshake-qualified writes land in the same cycle.
  always_comb begin
    w_aluc     = ALUC_ADD;
    w_alusrca  = SRCA_PC;
    w_alusrcb  = SRCB_RT;
    w_pcsource = PC_ALU;
    w_wpc      = 1'b0;
    w_iord     = 1'b0;
    w_wir      = 1'b0;
    w_wmem     = 1'b0;
    w_wreg     = 1'b0;
    w_regrt    = 1'b0;
    w_m2reg    = 1'b0;
    w_sext     = 1'b0;
    w_jal      = 1'b0;

    if (!reset) begin
      if (r_state != S_IF) begin
        w_sext  = w_dec_sext;
        w_regrt = w_dec_regrt;
      end
      case (r_state)
        S_IF: begin
          w_alusrcb = SRCB_FOUR;
          w_wir     = bus.mem_ready;
          w_wpc     = bus.mem_ready;
        end
        S_ID: begin
          w_alusrcb = SRCB_BR;
          case (w_iclass)
            CLS_J:   begin w_wpc = 1'b1; w_pcsource = PC_JUMP; end
            CLS_JAL: begin
              w_wpc = 1'b1; w_pcsource = PC_JUMP; w_wreg = 1'b1; w_jal = 1'b1;
            end
            CLS_JR:  begin w_wpc = 1'b1; w_pcsource = PC_RS; end
            default: ;
          endcase
        end
        S_EXE: begin
          w_aluc    = w_dec_aluc;
          w_alusrca = w_dec_alusrca;
          w_alusrcb = w_dec_alusrcb;
          if (w_iclass == CLS_BEQ) begin
            w_pcsource = PC_ALUOUT;
            w_wpc      = bus.z;
          end else if (w_iclass == CLS_BNE) begin
            w_pcsource = PC_ALUOUT;
            w_wpc      = ~bus.z;
          end
        end
        S_MEM: begin
          w_iord = 1'b1;
          if (w_iclass == CLS_SW) w_wmem = bus.mem_ready;
        end
        S_WB: begin
          w_wreg  = 1'b1;
          w_m2reg = (w_iclass == CLS_LW);
        end
        default: ;
      endcase
    end
  end

  assign bus.aluc     = w_aluc;
  assign bus.alusrca  = w_alusrca;
  assign bus.alusrcb  = w_alusrcb;
  assign bus.pcsource = w_pcsource;
  assign bus.wpc      = w_wpc;
  assign bus.iord     = w_iord;
  assign bus.wir      = w_wir;
  assign bus.wmem     = w_wmem;
  assign bus.wreg     = w_wreg;
  assign bus.regrt    = w_regrt;
  assign bus.m2reg    = w_m2reg;
  assign bus.sext     = w_sext;
  assign bus.jal      = w_jal;
  assign bus.state    = r_state;
`ifdef MC_ILLEGAL_TRAP_EN
  assign bus.illegal  = r_illegal;
`else
  assign bus.illegal  = 1'b0;
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// Table-driven bench for mc_control_unit: per-cycle vectors of inputs and expected
// outputs (-1 = don't care) flow through a scoreboard queue to a negedge checker.
module tb_mc_control_unit;

  localparam int DC = -1;

  typedef struct {
    string    name;
    bit       rst;
    bit [5:0] op;
    bit [5:0] func;
    bit       z;
    bit       mr;
    int st, aluc, asa, asb, pcs;
    int wpc, iord, wir, wmem, wreg, regrt, m2reg, sext, jal, ill;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl[$];
  vec_t exp_q[$];
  vec_t cur;

  always #5 clock = ~clock;

  mc_control_unit_if bus ();

  mc_control_unit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(string n, string f, int act, int exp);
    if (exp < 0) return;
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %0d expected %0d", n, f, act, exp);
    end
  endtask

  task automatic compare_all(vec_t v);
    check(v.name, "state",    int'(bus.state),    v.st);
    check(v.name, "aluc",     int'(bus.aluc),     v.aluc);
    check(v.name, "alusrca",  int'(bus.alusrca),  v.asa);
    check(v.name, "alusrcb",  int'(bus.alusrcb),  v.asb);
    check(v.name, "pcsource", int'(bus.pcsource), v.pcs);
    check(v.name, "wpc",      int'(bus.wpc),      v.wpc);
    check(v.name, "iord",     int'(bus.iord),     v.iord);
    check(v.name, "wir",      int'(bus.wir),      v.wir);
    check(v.name, "wmem",     int'(bus.wmem),     v.wmem);
    check(v.name, "wreg",     int'(bus.wreg),     v.wreg);
    check(v.name, "regrt",    int'(bus.regrt),    v.regrt);
    check(v.name, "m2reg",    int'(bus.m2reg),    v.m2reg);
    check(v.name, "sext",     int'(bus.sext),     v.sext);
    check(v.name, "jal",      int'(bus.jal),      v.jal);
    check(v.name, "illegal",  int'(bus.illegal),  v.ill);
  endtask

  // Vector builders: write enables default to 0, everything else to don't care.
  function automatic vec_t mk(string n, bit rst, bit [5:0] op, bit [5:0] func,
                              bit z, bit mr, int st);
    vec_t v;
    v.name = n; v.rst = rst; v.op = op; v.func = func; v.z = z; v.mr = mr;
    v.st = st; v.aluc = DC; v.asa = DC; v.asb = DC; v.pcs = DC;
    v.iord = DC; v.regrt = DC; v.m2reg = DC; v.sext = DC;
    v.wpc = 0; v.wir = 0; v.wmem = 0; v.wreg = 0; v.jal = 0; v.ill = 0;
    return v;
  endfunction

  function automatic vec_t s_if(string n, bit [5:0] op, bit [5:0] func, bit mr);
    vec_t v = mk({n, ".if"}, 0, op, func, 0, mr, 0);
    v.wir = mr; v.wpc = mr; v.iord = 0; v.asa = 0; v.asb = 1; v.aluc = 0; v.pcs = 0;
    return v;
  endfunction

  function automatic vec_t s_id(string n, bit [5:0] op, bit [5:0] func);
    vec_t v = mk({n, ".id"}, 0, op, func, 0, 1, 1);
    v.asa = 0; v.asb = 3; v.aluc = 0;
    return v;
  endfunction

  function automatic vec_t s_exe(string n, bit [5:0] op, bit [5:0] func, bit z,
                                 int aluc, int asa, int asb);
    vec_t v = mk({n, ".exe"}, 0, op, func, z, 1, 2);
    v.aluc = aluc; v.asa = asa; v.asb = asb;
    return v;
  endfunction

  function automatic vec_t s_mem(string n, bit [5:0] op, bit mr, int wmem);
    vec_t v = mk({n, ".mem"}, 0, op, 6'd0, 0, mr, 3);
    v.iord = 1; v.wmem = wmem;
    return v;
  endfunction

  function automatic vec_t s_wb(string n, bit [5:0] op, bit [5:0] func, int regrt, int m2reg);
    vec_t v = mk({n, ".wb"}, 0, op, func, 0, 1, 4);
    v.wreg = 1; v.regrt = regrt; v.m2reg = m2reg;
    return v;
  endfunction

  task automatic fetch(string n, bit [5:0] op, bit [5:0] func);
    tbl.push_back(s_if(n, op, func, 1));
    tbl.push_back(s_id(n, op, func));
  endtask

  task automatic branch(string n, bit [5:0] op, bit z, int wpc);
    vec_t v;
    fetch(n, op, 6'd0);
    tbl[$].sext = 1;
    v = s_exe(n, op, 6'd0, z, 4, 1, 0);
    v.pcs = 1; v.wpc = wpc;
    tbl.push_back(v);
  endtask

  task automatic apply(vec_t v);
    @(negedge clock);
    #1;
    reset         = v.rst;
    bus.op        = v.op;
    bus.func      = v.func;
    bus.z         = v.z;
    bus.mem_ready = v.mr;
    exp_q.push_back(v);
  endtask

  always begin
    @(negedge clock);
    #3;
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      compare_all(cur);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    bit [5:0] rop;
    reset = 1'b1;
    bus.op = '0; bus.func = '0; bus.z = 1'b0; bus.mem_ready = 1'b0;

    // Reset for two cycles with random op/z.
    rop = 6'($urandom_range(0, 63));
    v = mk("rst0", 1, rop, 6'd0, 1'($urandom_range(0, 1)), 1, DC);
    v.aluc = 0; v.ill = DC;
    tbl.push_back(v);
    rop = 6'($urandom_range(0, 63));
    v = mk("rst1", 1, rop, 6'd0, 1'($urandom_range(0, 1)), 1, 0);
    v.aluc = 0; v.asa = 0; v.asb = 0; v.pcs = 0;
    tbl.push_back(v);

    // add with one fetch stall, then full R-type flow.
    tbl.push_back(s_if("add_stall", 6'b000000, 6'b100000, 0));
    fetch("add", 6'b000000, 6'b100000);
    tbl.push_back(s_exe("add", 6'b000000, 6'b100000, 0, 0, 1, 0));
    tbl.push_back(s_wb("add", 6'b000000, 6'b100000, 0, 0));

    fetch("sra", 6'b000000, 6'b000011);
    tbl.push_back(s_exe("sra", 6'b000000, 6'b000011, 0, 15, 2, 0));
    tbl.push_back(s_wb("sra", 6'b000000, 6'b000011, 0, 0));

    fetch("lui", 6'b001111, 6'd0);
    v = s_exe("lui", 6'b001111, 6'd0, 0, 6, 3, DC); v.sext = 0;
    tbl.push_back(v);
    tbl.push_back(s_wb("lui", 6'b001111, 6'd0, 1, 0));

    fetch("xori", 6'b001110, 6'd0);
    v = s_exe("xori", 6'b001110, 6'd0, 0, 2, 1, 2); v.sext = 0;
    tbl.push_back(v);
    tbl.push_back(s_wb("xori", 6'b001110, 6'd0, 1, 0));

    branch("beq_z1", 6'b000100, 1, 1);
    branch("beq_z0", 6'b000100, 0, 0);
    branch("bne_z0", 6'b000101, 0, 1);
    branch("bne_z1", 6'b000101, 1, 0);

    fetch("j", 6'b000010, 6'd0);
    tbl[$].wpc = 1; tbl[$].pcs = 3;
    fetch("jal", 6'b000011, 6'd0);
    tbl[$].wpc = 1; tbl[$].pcs = 3; tbl[$].wreg = 1; tbl[$].jal = 1;
    fetch("jr", 6'b000000, 6'b001000);
    tbl[$].wpc = 1; tbl[$].pcs = 2;

    fetch("sw", 6'b101011, 6'd0);
    v = s_exe("sw", 6'b101011, 6'd0, 0, 0, 1, 2); v.sext = 1;
    tbl.push_back(v);
    tbl.push_back(s_mem("sw_wait", 6'b101011, 0, 0));
    tbl.push_back(s_mem("sw_go", 6'b101011, 1, 1));

    // lw with three wait cycles in MEM: 8 cycles in total.
    fetch("lw", 6'b100011, 6'd0);
    v = s_exe("lw", 6'b100011, 6'd0, 0, 0, 1, 2); v.sext = 1;
    tbl.push_back(v);
    for (int i = 0; i < 3; i++) tbl.push_back(s_mem("lw_wait", 6'b100011, 0, 0));
    tbl.push_back(s_mem("lw_go", 6'b100011, 1, 0));
    tbl.push_back(s_wb("lw", 6'b100011, 6'd0, 1, 1));

    // Reset arriving while in WB suppresses the register write.
    fetch("abort", 6'b000000, 6'b100010);
    tbl.push_back(s_exe("abort", 6'b000000, 6'b100010, 0, 4, 1, 0));
    v = mk("abort.rst", 1, 6'b000000, 6'b100010, 0, 1, 4);
    v.aluc = 0; v.asa = 0; v.asb = 0; v.pcs = 0;
    tbl.push_back(v);

    // Undefined R-type funct and undefined opcode.
    fetch("badfn", 6'b000000, 6'b111111);
`ifdef MC_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      v = mk("badfn.trap", 0, 6'b000000, 6'b111111, 1, 1, 5); v.ill = 1;
      tbl.push_back(v);
    end
    v = mk("badfn.rst", 1, 6'b000000, 6'd0, 0, 1, 5); v.ill = DC;
    tbl.push_back(v);
`endif
    fetch("badop", 6'b111111, 6'd0);
`ifdef MC_ILLEGAL_TRAP_EN
    for (int i = 0; i < 4; i++) begin
      v = mk("badop.trap", 0, 6'($urandom_range(0, 63)), 6'd0, 1, 1, 5); v.ill = 1;
      tbl.push_back(v);
    end
    v = mk("badop.rst", 1, 6'b111111, 6'd0, 0, 1, 5); v.ill = DC;
    tbl.push_back(v);
`endif
    tbl.push_back(s_if("end", 6'b000000, 6'b100000, 1));

    foreach (tbl[i]) apply(tbl[i]);

    @(negedge clock);
    @(negedge clock);
    #5;
    check("scoreboard", "drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
